branch_resolve_unit: RTL

Execute-stage branch resolver that consumes the ALU condition flags (cf, zf, vf, sf from the subtract path) and decides whether a branch or jump in EX is actually taken. It compares that outcome with the fetch-stage prediction and, on a mismatch, issues a registered PC redirect. It then holds a multi-cycle flush of the younger pipeline stages. It sits between the EX-stage ALU and the IF/ID/EX pipeline registers.

---
 rtl/branch_resolve_unit_pkg.sv | 17 +
 rtl/branch_resolve_unit_if.sv | 52 +++++
 rtl/branch_cond.sv | 27 ++
 rtl/branch_resolve_unit.sv | 123 ++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the EX-stage branch resolver.
// Holds branch condition codes and the resolver FSM state encoding.
package rv_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        BRU_IDLE  = 1'b0,
        BRU_FLUSH = 1'b1
    } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage <-> branch resolver bundle.
// Statistics ports exist only when BRU_STATS_EN is defined.
interface branch_resolve_unit_if #(
    parameter int N = 32
`ifdef BRU_STATS_EN
    ,
    parameter int CNT_W = 32
`endif
);
    logic         ex_valid;
    logic         ex_branch;
    logic         ex_jump;
    logic [2:0]   ex_funct3;
    logic         cf;
    logic         zf;
    logic         vf;
    logic         sf;
    logic [N-1:0] ex_target;
    logic [N-1:0] ex_pc_plus4;
    logic         ex_pred_taken;
    logic         stall;
    logic         redirect;
    logic [N-1:0] redirect_pc;
    logic         flush;
    logic         busy;
    logic         taken;
`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;
`endif

    modport master (
        output ex_valid, ex_branch, ex_jump, ex_funct3,
        output cf, zf, vf, sf,
        output ex_target, ex_pc_plus4, ex_pred_taken, stall,
`ifdef BRU_STATS_EN
        input  br_count, mispred_count,
`endif
        input  redirect, redirect_pc, flush, busy, taken
    );

    modport slave (
        input  ex_valid, ex_branch, ex_jump, ex_funct3,
        input  cf, zf, vf, sf,
        input  ex_target, ex_pc_plus4, ex_pred_taken, stall,
`ifdef BRU_STATS_EN
        output br_count, mispred_count,
`endif
        output redirect, redirect_pc, flush, busy, taken
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition from A-B subtract flags.
// cf is the carry-out of A+~B+1, so cf=1 means no borrow (A>=B unsigned).
module branch_cond
    import rv_branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       cf,
    input  logic       zf,
    input  logic       vf,
    input  logic       sf,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zf;
            F3_BNE:  cond = ~zf;
            F3_BLT:  cond = sf ^ vf;
            F3_BGE:  cond = ~(sf ^ vf);
            F3_BLTU: cond = ~cf;
            F3_BGEU: cond = cf;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: mispredict detection, PC redirect, flush FSM.
// Optional statistics counters are enabled with BRU_STATS_EN.
module branch_resolve_unit
    import rv_branch_pkg::*;
#(
    parameter int N            = 32,
    parameter int FLUSH_CYCLES = 2
`ifdef BRU_STATS_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave bus
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

    bru_state_e   state_q;
    bru_state_e   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic         redirect_q;
    logic         redirect_d;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_d;
    logic         taken_q;
    logic         taken_d;
    logic         cond;
    logic         actual;
    logic         sample;
    logic         mispred;

    branch_cond u_cond (
        .funct3 (bus.ex_funct3),
        .cf     (bus.cf),
        .zf     (bus.zf),
        .vf     (bus.vf),
        .sf     (bus.sf),
        .cond   (cond)
    );

    // Jump dominates a simultaneously asserted branch flag.
    assign actual  = bus.ex_jump | (bus.ex_branch & cond);
    assign sample  = (state_q == BRU_IDLE) & bus.ex_valid & ~bus.stall;
    assign mispred = actual != bus.ex_pred_taken;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        redirect_d = 1'b0;
        pc_d       = pc_q;
        taken_d    = taken_q;
        unique case (state_q)
            BRU_IDLE: begin
                if (sample) begin
                    taken_d = actual;
                    if (mispred) begin
                        state_d    = BRU_FLUSH;
                        cnt_d      = CNT_LOAD;
                        redirect_d = 1'b1;
                        pc_d       = actual ? bus.ex_target
                                            : bus.ex_pc_plus4;
                    end
                end
            end
            BRU_FLUSH: begin
                // Wrong-path instructions are dropped; stall is ignored.
                if (cnt_q == '0) begin
                    state_d = BRU_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = BRU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BRU_IDLE;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            pc_q       <= '0;
            taken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            pc_q       <= pc_d;
            taken_q    <= taken_d;
        end
    end

    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = pc_q;
    assign bus.flush       = (state_q == BRU_FLUSH);
    assign bus.busy        = (state_q == BRU_FLUSH);
    assign bus.taken       = taken_q;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] br_q;
    logic [CNT_W-1:0] mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (sample) begin
            br_q <= br_q + 1'b1;
            if (mispred) begin
                mp_q <= mp_q + 1'b1;
            end
        end
    end

    assign bus.br_count      = br_q;
    assign bus.mispred_count = mp_q;
`endif

endmodule
